store_align_unit: RTL and testbench

Parametrised store path between the execute stage and main memory. It takes one store request per handshake, places the data on byte lanes with a matching write strobe, and drives a valid/ready memory port. Stores that cross a bus-word boundary are split into two bus beats. Naturally misaligned stores to the MMIO region, and oversize stores, are rejected with an error and produce no bus traffic.

---
 rtl/store_align_unit.sv | 138 +++++++++++++
 tb/tb_store_align_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/store_align_unit.sv
// Store alignment unit: places right-justified store data on byte lanes and splits stores that cross a bus word into two beats.
// Latency: done 2 cycles after accept for a single beat, 3 for a split, 1 for a rejected request; +1 per mem_ready-low cycle.
// Backpressure: req_ready is high only in IDLE; beats hold mem_addr/mem_wdata/mem_wstrb stable until mem_ready.
//
// Ports:
//   clk, rst_n                      rising-edge clock, async active-low reset
//   req_valid/req_ready             store request handshake (addr, data, size = log2 bytes)
//   mem_valid/mem_ready             bus beat handshake (mem_addr NB-aligned, mem_wdata, mem_wstrb)
//   done, err                       one-cycle completion pulse; err marks a rejected request
module store_align_unit #(
   parameter int DW       = 32,
   parameter int AW       = 32,
   parameter int MMIO_BIT = 31
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [AW-1:0]   req_addr,
   input  logic [DW-1:0]   req_data,
   input  logic [1:0]      req_size,
   output logic            mem_valid,
   input  logic            mem_ready,
   output logic [AW-1:0]   mem_addr,
   output logic [DW-1:0]   mem_wdata,
   output logic [DW/8-1:0] mem_wstrb,
   output logic            done,
   output logic            err
);

   localparam int NB = DW / 8;
   localparam int OW = $clog2(NB);

   typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

   state_t          state;
   logic            split;
   logic [DW-1:0]   hi_data;
   logic [NB-1:0]   hi_strb;

   logic [OW-1:0]   off;
   logic [OW-1:0]   size_mask;
   logic [AW-1:0]   base;
   logic [2*DW-1:0] wide_data;
   logic [2*NB-1:0] wide_strb;
   logic            illegal;

   // Lane placement over a double-width window; the upper half is the second beat of a split.
   always_comb begin
      off  = req_addr[OW-1:0];
      base = {req_addr[AW-1:OW], {OW{1'b0}}};

      for (int i = 0; i < 2*NB; i++) begin
         wide_strb[i] = (i >= int'(off)) && (i < int'(off) + (1 << req_size));
      end

      // Zero unstrobed lanes so junk above the store size never reaches the bus.
      wide_data = {{DW{1'b0}}, req_data} << {off, 3'b000};
      for (int i = 0; i < 2*NB; i++) begin
         if (!wide_strb[i]) begin
            wide_data[8*i +: 8] = 8'h00;
         end
      end

      // off mod n reduces to the low req_size bits of off being non-zero.
      for (int i = 0; i < OW; i++) begin
         size_mask[i] = (i < int'(req_size));
      end

      illegal = (int'(req_size) > OW) ||
                (req_addr[MMIO_BIT] && ((off & size_mask) != '0));
   end

   assign req_ready = (state == IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         mem_valid <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wstrb <= '0;
         done      <= 1'b0;
         err       <= 1'b0;
         split     <= 1'b0;
         hi_data   <= '0;
         hi_strb   <= '0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  if (illegal) begin
                     done <= 1'b1;
                     err  <= 1'b1;
                  end else begin
                     state     <= BEAT0;
                     mem_valid <= 1'b1;
                     mem_addr  <= base;
                     mem_wdata <= wide_data[DW-1:0];
                     mem_wstrb <= wide_strb[NB-1:0];
                     hi_data   <= wide_data[2*DW-1:DW];
                     hi_strb   <= wide_strb[2*NB-1:NB];
                     split     <= |wide_strb[2*NB-1:NB];
                  end
               end
            end
            BEAT0: begin
               if (mem_ready) begin
                  if (split) begin
                     state     <= BEAT1;
                     mem_addr  <= mem_addr + AW'(NB);   // wraps modulo 2^AW
                     mem_wdata <= hi_data;
                     mem_wstrb <= hi_strb;
                  end else begin
                     state     <= IDLE;
                     mem_valid <= 1'b0;
                     done      <= 1'b1;
                  end
               end
            end
            BEAT1: begin
               if (mem_ready) begin
                  state     <= IDLE;
                  mem_valid <= 1'b0;
                  done      <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               mem_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_store_align_unit.sv
module tb_store_align_unit;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // 32-bit bus instance
   logic        a_req_valid, a_req_ready;
   logic [31:0] a_req_addr, a_req_data;
   logic [1:0]  a_req_size;
   logic        a_mem_valid, a_mem_ready;
   logic [31:0] a_mem_addr, a_mem_wdata;
   logic [3:0]  a_mem_wstrb;
   logic        a_done, a_err;

   // 64-bit bus instance
   logic        b_req_valid, b_req_ready;
   logic [31:0] b_req_addr;
   logic [63:0] b_req_data;
   logic [1:0]  b_req_size;
   logic        b_mem_valid, b_mem_ready;
   logic [31:0] b_mem_addr;
   logic [63:0] b_mem_wdata;
   logic [7:0]  b_mem_wstrb;
   logic        b_done, b_err;

   store_align_unit #(.DW(32), .AW(32), .MMIO_BIT(31)) u_dut32 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(a_req_valid), .req_ready(a_req_ready), .req_addr(a_req_addr),
      .req_data(a_req_data), .req_size(a_req_size),
      .mem_valid(a_mem_valid), .mem_ready(a_mem_ready), .mem_addr(a_mem_addr),
      .mem_wdata(a_mem_wdata), .mem_wstrb(a_mem_wstrb),
      .done(a_done), .err(a_err)
   );

   store_align_unit #(.DW(64), .AW(32), .MMIO_BIT(31)) u_dut64 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(b_req_valid), .req_ready(b_req_ready), .req_addr(b_req_addr),
      .req_data(b_req_data), .req_size(b_req_size),
      .mem_valid(b_mem_valid), .mem_ready(b_mem_ready), .mem_addr(b_mem_addr),
      .mem_wdata(b_mem_wdata), .mem_wstrb(b_mem_wstrb),
      .done(b_done), .err(b_err)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [1:0]  size;
      logic        ill;
      int          beats;
      logic [31:0] a0;
      logic [31:0] d0;
      logic [3:0]  s0;
      logic [31:0] a1;
      logic [31:0] d1;
      logic [3:0]  s1;
   } vec_t;

   localparam int NV = 12;
   vec_t vecs [NV];

   initial begin
      vecs[0]  = '{32'h0000_0100, 32'hDDCC_BBAA, 2'd2, 1'b0, 1, 32'h0000_0100, 32'hDDCC_BBAA, 4'hF, 32'h0, 32'h0, 4'h0};
      vecs[1]  = '{32'h0000_0103, 32'h0000_0055, 2'd0, 1'b0, 1, 32'h0000_0100, 32'h5500_0000, 4'h8, 32'h0, 32'h0, 4'h0};
      vecs[2]  = '{32'h0000_0102, 32'h4433_2211, 2'd2, 1'b0, 2, 32'h0000_0100, 32'h2211_0000, 4'hC, 32'h0000_0104, 32'h0000_4433, 4'h3};
      vecs[3]  = '{32'h8000_0001, 32'h0000_BEEF, 2'd1, 1'b1, 0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0};
      vecs[4]  = '{32'h8000_0002, 32'h0000_BEEF, 2'd1, 1'b0, 1, 32'h8000_0000, 32'hBEEF_0000, 4'hC, 32'h0, 32'h0, 4'h0};
      vecs[5]  = '{32'h0000_0000, 32'h1234_5678, 2'd3, 1'b1, 0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0};
      vecs[6]  = '{32'h8000_0004, 32'h1234_5678, 2'd2, 1'b0, 1, 32'h8000_0004, 32'h1234_5678, 4'hF, 32'h0, 32'h0, 4'h0};
      vecs[7]  = '{32'h8000_0003, 32'h0000_007A, 2'd0, 1'b0, 1, 32'h8000_0000, 32'h7A00_0000, 4'h8, 32'h0, 32'h0, 4'h0};
      vecs[8]  = '{32'h0000_0103, 32'h0000_A1B2, 2'd1, 1'b0, 2, 32'h0000_0100, 32'hB200_0000, 4'h8, 32'h0000_0104, 32'h0000_00A1, 4'h1};
      vecs[9]  = '{32'h0000_0001, 32'hABCD_1234, 2'd1, 1'b0, 1, 32'h0000_0000, 32'h0012_3400, 4'h6, 32'h0, 32'h0, 4'h0};
      vecs[10] = '{32'h7FFF_FFFE, 32'h4433_2211, 2'd2, 1'b0, 2, 32'h7FFF_FFFC, 32'h2211_0000, 4'hC, 32'h8000_0000, 32'h0000_4433, 4'h3};
      vecs[11] = '{32'h8000_0002, 32'h4433_2211, 2'd2, 1'b1, 0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0};

      rst_n       = 1'b0;
      a_req_valid = 1'b0; a_req_addr = '0; a_req_data = '0; a_req_size = '0; a_mem_ready = 1'b1;
      b_req_valid = 1'b0; b_req_addr = '0; b_req_data = '0; b_req_size = '0; b_mem_ready = 1'b1;

      // Reset values
      #12;
      chk("rst_req_ready", a_req_ready, 1);
      chk("rst_mem_valid", a_mem_valid, 0);
      chk("rst_mem_addr",  a_mem_addr,  0);
      chk("rst_mem_wdata", a_mem_wdata, 0);
      chk("rst_mem_wstrb", a_mem_wstrb, 0);
      chk("rst_done",      a_done,      0);
      chk("rst_err",       a_err,       0);
      chk("rst64_mem_valid", b_mem_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Table-driven single requests, mem_ready held high
      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         chk($sformatf("v%0d_req_ready", i), a_req_ready, 1);
         a_req_valid = 1'b1;
         a_req_addr  = vecs[i].addr;
         a_req_data  = vecs[i].data;
         a_req_size  = vecs[i].size;
         @(negedge clk);
         a_req_valid = 1'b0;
         if (vecs[i].ill) begin
            chk($sformatf("v%0d_ill_mem_valid", i), a_mem_valid, 0);
            chk($sformatf("v%0d_ill_done", i), a_done, 1);
            chk($sformatf("v%0d_ill_err", i),  a_err,  1);
            @(negedge clk);
            chk($sformatf("v%0d_ill_mem_valid2", i), a_mem_valid, 0);
         end else begin
            chk($sformatf("v%0d_b0_valid", i), a_mem_valid, 1);
            chk($sformatf("v%0d_b0_addr", i),  a_mem_addr,  vecs[i].a0);
            chk($sformatf("v%0d_b0_wdata", i), a_mem_wdata, vecs[i].d0);
            chk($sformatf("v%0d_b0_wstrb", i), a_mem_wstrb, vecs[i].s0);
            chk($sformatf("v%0d_b0_done", i),  a_done,      0);
            chk($sformatf("v%0d_b0_req_ready", i), a_req_ready, 0);
            if (vecs[i].beats == 2) begin
               @(negedge clk);
               chk($sformatf("v%0d_b1_valid", i), a_mem_valid, 1);
               chk($sformatf("v%0d_b1_addr", i),  a_mem_addr,  vecs[i].a1);
               chk($sformatf("v%0d_b1_wdata", i), a_mem_wdata, vecs[i].d1);
               chk($sformatf("v%0d_b1_wstrb", i), a_mem_wstrb, vecs[i].s1);
               chk($sformatf("v%0d_b1_done", i),  a_done,      0);
            end
            @(negedge clk);
            chk($sformatf("v%0d_done", i),      a_done,      1);
            chk($sformatf("v%0d_err", i),       a_err,       0);
            chk($sformatf("v%0d_end_valid", i), a_mem_valid, 0);
            chk($sformatf("v%0d_end_ready", i), a_req_ready, 1);
         end
         @(negedge clk);
         chk($sformatf("v%0d_done_pulse", i), a_done, 0);
      end

      // Split store with 3 stall cycles per beat, next request held pending
      @(negedge clk);
      a_mem_ready = 1'b0;
      a_req_valid = 1'b1;
      a_req_addr  = 32'h0000_0102;
      a_req_data  = 32'h4433_2211;
      a_req_size  = 2'd2;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         chk($sformatf("bp_c%0d_valid", c),     a_mem_valid, 1);
         chk($sformatf("bp_c%0d_addr", c),      a_mem_addr,  (c <= 4) ? 32'h0000_0100 : 32'h0000_0104);
         chk($sformatf("bp_c%0d_wdata", c),     a_mem_wdata, (c <= 4) ? 32'h2211_0000 : 32'h0000_4433);
         chk($sformatf("bp_c%0d_wstrb", c),     a_mem_wstrb, (c <= 4) ? 4'hC : 4'h3);
         chk($sformatf("bp_c%0d_done", c),      a_done,      0);
         chk($sformatf("bp_c%0d_req_ready", c), a_req_ready, 0);
         if (c == 1) begin
            a_req_addr = 32'h0000_0103;
            a_req_data = 32'h0000_0055;
            a_req_size = 2'd0;
         end
         a_mem_ready = (c == 4 || c == 8);
      end
      @(negedge clk);
      chk("bp_done",      a_done,      1);
      chk("bp_err",       a_err,       0);
      chk("bp_end_valid", a_mem_valid, 0);
      chk("bp_req_ready", a_req_ready, 1);
      @(negedge clk);
      a_req_valid = 1'b0;
      chk("ovl_valid", a_mem_valid, 1);
      chk("ovl_addr",  a_mem_addr,  32'h0000_0100);
      chk("ovl_wdata", a_mem_wdata, 32'h5500_0000);
      chk("ovl_wstrb", a_mem_wstrb, 4'h8);
      @(negedge clk);
      chk("ovl_done", a_done, 1);
      chk("ovl_err",  a_err,  0);
      @(negedge clk);

      // 64-bit bus: dword split across 0x80000000
      b_req_valid = 1'b1;
      b_req_addr  = 32'h7FFF_FFFC;
      b_req_data  = 64'h8877_6655_4433_2211;
      b_req_size  = 2'd3;
      @(negedge clk);
      b_req_valid = 1'b0;
      chk("d64_b0_valid", b_mem_valid, 1);
      chk("d64_b0_addr",  b_mem_addr,  32'h7FFF_FFF8);
      chk("d64_b0_wdata", b_mem_wdata, 64'h4433_2211_0000_0000);
      chk("d64_b0_wstrb", b_mem_wstrb, 8'hF0);
      @(negedge clk);
      chk("d64_b1_valid", b_mem_valid, 1);
      chk("d64_b1_addr",  b_mem_addr,  32'h8000_0000);
      chk("d64_b1_wdata", b_mem_wdata, 64'h0000_0000_8877_6655);
      chk("d64_b1_wstrb", b_mem_wstrb, 8'h0F);
      @(negedge clk);
      chk("d64_done",  b_done,      1);
      chk("d64_err",   b_err,       0);
      chk("d64_valid", b_mem_valid, 0);
      @(negedge clk);

      // Same request, reset pulsed during beat 1
      b_req_valid = 1'b1;
      @(negedge clk);
      b_req_valid = 1'b0;
      chk("rst64_b0_valid", b_mem_valid, 1);
      @(negedge clk);
      chk("rst64_b1_valid", b_mem_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("rst64_valid_now", b_mem_valid, 0);
      chk("rst64_addr_now",  b_mem_addr,  0);
      chk("rst64_strb_now",  b_mem_wstrb, 0);
      chk("rst64_req_ready", b_req_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      chk("rst64_done_0", b_done, 0);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         chk($sformatf("rst64_done_%0d", k),  b_done,      0);
         chk($sformatf("rst64_valid_%0d", k), b_mem_valid, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
